// File: rtl/dma_ci_engine.sv
// Custom-instruction DMA engine: CI-visible scratchpad plus control registers, and a bus master
// that moves blocks between the shared bus and the scratchpad. Optional feature: `DMA_IRQ_EN.
module dma_ci_engine #(
    parameter logic [7:0] CUSTOM_ID      = 8'h00,
    parameter int         MEM_ADDR_WIDTH = 9,
    parameter int         BLOCK_WIDTH    = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  ciN,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result,
    output logic        requestOut,
    input  logic        grantedIn,
    input  logic [31:0] addressDataIn,
    input  logic        dataValidIn,
    input  logic        endTransactionIn,
    input  logic        busErrorIn,
    input  logic        busyIn,
    output logic [31:0] addressDataOut,
    output logic [3:0]  byteEnablesOut,
    output logic [7:0]  burstSizeOut,
    output logic        readNotWriteOut,
    output logic        beginTransactionOut,
    output logic        endTransactionOut,
    output logic        dataValidOut,
    output logic        irqOut
);
    // state        | meaning
    // S_IDLE       | no transfer, waiting for a control start
    // S_REQUEST    | bus requested, waiting for grant
    // S_INIT_BURST | begin strobe with address and burst size
    // S_DO_READ    | capturing read beats into the scratchpad
    // S_DO_WRITE   | presenting scratchpad words as write beats
    // S_END_BURST  | burst closed; next burst or finish
    // S_ERROR      | bus error abort, end strobe, then idle
    typedef enum logic [2:0] {
        S_IDLE, S_REQUEST, S_INIT_BURST, S_DO_READ, S_DO_WRITE, S_END_BURST, S_ERROR
    } state_t;

    localparam int W     = MEM_ADDR_WIDTH;
    localparam int CW    = (BLOCK_WIDTH > 9) ? BLOCK_WIDTH : 9;
    localparam int DEPTH = 2 ** W;
`ifdef DMA_IRQ_EN
    localparam logic IRQ_EN = 1'b1;
`else
    localparam logic IRQ_EN = 1'b0;
`endif

    state_t r_state, w_state_nxt;

    logic [31:0]            r_mem [DEPTH];
    logic [31:0]            r_mem_qa, r_mem_qb;
    logic [31:0]            r_bus_start, r_bus_addr, r_result;
    logic [W-1:0]           r_mem_start, r_mem_ptr;
    logic [BLOCK_WIDTH-1:0] r_block_size, r_remaining;
    logic [7:0]             r_burst_size, r_burst_len;
    logic [CW-1:0]          r_left;
    logic [2:0]             r_rd_sel;
    logic                   r_error, r_irq, r_dir, r_rd_pend, r_done;

    logic [2:0]    w_sel;
    logic [W-1:0]  w_ci_addr, w_rd_addr_b;
    logic [CW-1:0] w_burst_words, w_rem_ext, w_beats, w_beats_m1;
    logic [31:0]   w_rd_data;
    logic w_ci_hit, w_ci_wr, w_ci_rd, w_ctrl_start, w_go, w_go_zero;
    logic w_busy, w_accept, w_dma_we, w_complete, w_unused;

    assign w_ci_hit     = start && (ciN == CUSTOM_ID);
    assign w_ci_wr      = w_ci_hit && valueA[W];
    assign w_ci_rd      = w_ci_hit && !valueA[W];
    assign w_sel        = valueA[W+3:W+1];
    assign w_ci_addr    = valueA[W-1:0];
    assign w_busy       = (r_state != S_IDLE);
    assign w_ctrl_start = w_ci_wr && (w_sel == 3'd5) && (valueB[0] || valueB[1]) && !w_busy;
    assign w_go         = w_ctrl_start && (r_block_size != '0);
    assign w_go_zero    = w_ctrl_start && (r_block_size == '0);

    assign w_burst_words = CW'(r_burst_len) + CW'(1);
    assign w_rem_ext     = CW'(r_remaining);
    assign w_beats       = (w_rem_ext < w_burst_words) ? w_rem_ext : w_burst_words;
    assign w_beats_m1    = w_beats - CW'(1);

    assign w_accept    = (r_state == S_DO_WRITE) && !busyIn && !busErrorIn;
    assign w_dma_we    = (r_state == S_DO_READ) && dataValidIn && !busErrorIn;
    // Look one word ahead on accept so back-to-back write beats need no bubble.
    assign w_rd_addr_b = w_accept ? r_mem_ptr + W'(1) : r_mem_ptr;
    assign w_complete  = (r_state == S_END_BURST) && (r_remaining == '0);
    assign w_unused    = ^{valueA[31:W+4], w_beats_m1};

    // Port A (CI) written first so a same-address DMA write overrides it.
    always_ff @(posedge clock) begin
        if (w_ci_wr && w_sel == 3'd0) r_mem[w_ci_addr] <= valueB;
        if (w_dma_we) r_mem[r_mem_ptr] <= addressDataIn;
        r_mem_qa <= r_mem[w_ci_addr];
        r_mem_qb <= r_mem[w_rd_addr_b];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bus_start  <= '0;
            r_mem_start  <= '0;
            r_block_size <= '0;
            r_burst_size <= '0;
            r_error      <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            if (w_ci_wr) begin
                case (w_sel)
                    3'd1: r_bus_start  <= valueB;
                    3'd2: r_mem_start  <= valueB[W-1:0];
                    3'd3: r_block_size <= valueB[BLOCK_WIDTH-1:0];
                    3'd4: r_burst_size <= valueB[7:0];
                    3'd5: if (valueB[2]) begin
                        r_error <= 1'b0;
                        r_irq   <= 1'b0;
                    end
                    default: ;
                endcase
            end
            if (w_go_zero || w_complete) r_irq <= IRQ_EN;
            if (r_state == S_ERROR) r_error <= 1'b1;
        end
    end

    always_comb begin
        w_rd_data = '0;
        case (r_rd_sel)
            3'd0: w_rd_data = r_mem_qa;
            3'd1: w_rd_data = r_bus_start;
            3'd2: w_rd_data = 32'(r_mem_start);
            3'd3: w_rd_data = 32'(r_block_size);
            3'd4: w_rd_data = 32'(r_burst_size);
            3'd5: w_rd_data = {29'd0, r_irq, r_error, w_busy};
            default: w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_pend <= 1'b0;
            r_rd_sel  <= '0;
            r_done    <= 1'b0;
            r_result  <= '0;
        end else begin
            r_rd_pend <= w_ci_rd;
            r_rd_sel  <= w_sel;
            r_done    <= w_ci_wr || r_rd_pend;
            r_result  <= r_rd_pend ? w_rd_data : '0;
        end
    end

    assign done   = r_done;
    assign result = r_result;
    assign irqOut = r_irq;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dir       <= 1'b0;
            r_bus_addr  <= '0;
            r_mem_ptr   <= '0;
            r_remaining <= '0;
            r_burst_len <= '0;
            r_left      <= '0;
        end else begin
            if (w_go) begin
                r_dir       <= !valueB[0];
                r_bus_addr  <= r_bus_start;
                r_mem_ptr   <= r_mem_start;
                r_remaining <= r_block_size;
                r_burst_len <= r_burst_size;
            end
            case (r_state)
                S_INIT_BURST: if (!busErrorIn) begin
                    r_left      <= w_beats;
                    r_remaining <= r_remaining - w_beats[BLOCK_WIDTH-1:0];
                    r_bus_addr  <= r_bus_addr + (32'(w_beats) << 2);
                end
                S_DO_READ: if (w_dma_we) r_mem_ptr <= r_mem_ptr + W'(1);
                S_DO_WRITE: if (w_accept) begin
                    r_mem_ptr <= r_mem_ptr + W'(1);
                    r_left    <= r_left - CW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt         = r_state;
        requestOut          = 1'b0;
        beginTransactionOut = 1'b0;
        endTransactionOut   = 1'b0;
        dataValidOut        = 1'b0;
        readNotWriteOut     = 1'b0;
        addressDataOut      = '0;
        byteEnablesOut      = '0;
        burstSizeOut        = '0;
        case (r_state)
            S_IDLE: if (w_go) w_state_nxt = S_REQUEST;
            S_REQUEST: begin
                requestOut = 1'b1;
                if (grantedIn) w_state_nxt = S_INIT_BURST;
            end
            S_INIT_BURST: begin
                requestOut          = 1'b1;
                beginTransactionOut = 1'b1;
                addressDataOut      = r_bus_addr;
                byteEnablesOut      = 4'hF;
                burstSizeOut        = w_beats_m1[7:0];
                readNotWriteOut     = !r_dir;
                if (busErrorIn) w_state_nxt = S_ERROR;
                else            w_state_nxt = r_dir ? S_DO_WRITE : S_DO_READ;
            end
            S_DO_READ: begin
                requestOut = 1'b1;
                if (busErrorIn)            w_state_nxt = S_ERROR;
                else if (endTransactionIn) w_state_nxt = S_END_BURST;
            end
            S_DO_WRITE: begin
                requestOut     = 1'b1;
                dataValidOut   = 1'b1;
                addressDataOut = r_mem_qb;
                if (busErrorIn)                             w_state_nxt = S_ERROR;
                else if (!busyIn && r_left == CW'(1))       w_state_nxt = S_END_BURST;
            end
            S_END_BURST: begin
                endTransactionOut = r_dir;
                w_state_nxt = (r_remaining != '0) ? S_REQUEST : S_IDLE;
            end
            S_ERROR: begin
                endTransactionOut = 1'b1;
                w_state_nxt       = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end
endmodule
